ledport_pwm_fta64: RTL

- Parametrised successor of the FTA64 LED port: N LED outputs behind a small FTA64 register file.
- Per-LED PWM brightness, per-LED blink enable with selectable rate, and full register readback.
- Keeps the heartbeat behaviour: all LEDs follow a slow free-running counter bit until software first writes the port.
- Sits on the FTA64 I/O bus as a slave selected by an external decoder via cs.

---
 rtl/ledport_pwm_fta64.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ledport_pwm_fta64.sv
// FTA64 LED port with per-LED PWM brightness, blink and a power-on heartbeat.
// Register select is adr[5:3]: OUT, BLINK, DUTY, CTRL, ID. The remaining slots read as zero.

package fta_bus_pkg;
    typedef enum logic [2:0] {CLASSIC = 3'd0, FIXED = 3'd1, INCR = 3'd2, ERC = 3'd7} fta_cti_t;
    typedef enum logic [1:0] {OKAY = 2'd0, DECERR = 2'd1, PROTERR = 2'd2, ERR = 2'd3} fta_err_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        fta_cti_t    cti;
        logic [7:0]  sel;
        logic [7:0]  tid;
        logic [31:0] adr;
        logic [63:0] dat;
    } fta_cmd_request64_t;

    typedef struct packed {
        logic        ack;
        logic        rty;
        fta_err_t    err;
        logic [3:0]  pri;
        logic [7:0]  tid;
        logic [31:0] adr;
        logic [63:0] dat;
    } fta_cmd_response64_t;
endpackage

module ledport_pwm_fta64
    import fta_bus_pkg::*;
#(
    parameter int NLED       = 8,
    parameter int PWM_BITS   = 8,
    parameter int HB_BIT     = 28,
    parameter int PRESCALE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  fta_cmd_request64_t  req,
    output fta_cmd_response64_t resp,
    output logic [NLED-1:0]     led
);

    localparam int CW = HB_BIT + 1;
    localparam logic [4:0] BSEL_MAX = 5'(HB_BIT);
    // The nominal reset rate is bit 24; small counters clamp it so it always names a real bit.
    localparam logic [4:0] BSEL_RST = 5'((HB_BIT < 24) ? HB_BIT : 24);

    logic [NLED-1:0]                out_q, out_d;
    logic [NLED-1:0]                blink_q, blink_d;
    logic [NLED-1:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [4:0]                     bsel_q, bsel_d;
    logic [PRESCALE_W-1:0]          prescale_q, prescale_d;
    logic                           hbf_q, hbf_d;
    logic                           wr_seen_q, wr_seen_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [PRESCALE_W-1:0]          pre_q, pre_d;
    logic [PWM_BITS-1:0]            pwm_q, pwm_d;
    logic [NLED-1:0]                led_q, led_d;
    fta_cmd_response64_t            resp_q, resp_d;

    logic        wr;
    logic [2:0]  rsel;
    logic [63:0] rdata;
    logic [CW-1:0] cnt_sh;
    logic        blink_ph;
    logic [NLED-1:0] pwm_on;
    logic        unused_req;

    assign wr         = cs & req.we;
    assign rsel       = req.adr[5:3];
    assign unused_req = ^{req.cyc, req.stb, req.sel, req.dat};

    // Register file writes; byte enables are ignored, every write is full width.
    always_comb begin
        out_d      = out_q;
        blink_d    = blink_q;
        duty_d     = duty_q;
        bsel_d     = bsel_q;
        prescale_d = prescale_q;
        hbf_d      = hbf_q;
        wr_seen_d  = wr_seen_q;
        if (wr) begin
            case (rsel)
                3'd0: begin
                    out_d     = req.dat[NLED-1:0];
                    wr_seen_d = 1'b1;
                end
                3'd1: begin
                    blink_d   = req.dat[NLED-1:0];
                    wr_seen_d = 1'b1;
                end
                3'd2: begin
                    for (int i = 0; i < NLED; i++) duty_d[i] = req.dat[i*8 +: PWM_BITS];
                    wr_seen_d = 1'b1;
                end
                3'd3: begin
                    bsel_d     = (req.dat[4:0] > BSEL_MAX) ? BSEL_MAX : req.dat[4:0];
                    prescale_d = req.dat[16 +: PRESCALE_W];
                    hbf_d      = req.dat[32];
                    wr_seen_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Readback mux, zero-extended to the bus width.
    always_comb begin
        rdata = '0;
        case (rsel)
            3'd0: rdata[NLED-1:0] = out_q;
            3'd1: rdata[NLED-1:0] = blink_q;
            3'd2: for (int i = 0; i < NLED; i++) rdata[i*8 +: PWM_BITS] = duty_q[i];
            3'd3: begin
                rdata[4:0]              = bsel_q;
                rdata[16 +: PRESCALE_W] = prescale_q;
                rdata[32]               = hbf_q;
            end
            3'd4: rdata = {32'h4C454450, 8'(NLED), 8'(PWM_BITS), 16'd0};
            default: rdata = '0;
        endcase
    end

    // Free counter, PWM prescaler (reload uses the value held before any same-cycle write), LED and response.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        pwm_d = pwm_q;
        if (pre_q == '0) begin
            pre_d = prescale_q;
            pwm_d = pwm_q + PWM_BITS'(1);
        end else begin
            pre_d = pre_q - PRESCALE_W'(1);
        end

        cnt_sh   = cnt_q >> bsel_q;
        blink_ph = cnt_sh[0];
        pwm_on   = '0;
        led_d    = '0;
        for (int i = 0; i < NLED; i++) begin
            pwm_on[i] = (duty_q[i] == '1) | (pwm_q < duty_q[i]);
            if (!wr_seen_q | hbf_q) led_d[i] = cnt_q[HB_BIT];
            else led_d[i] = out_q[i] & pwm_on[i] & (~blink_q[i] | blink_ph);
        end

        resp_d     = '0;
        resp_d.ack = cs & (~req.we | (req.cti == ERC));
        resp_d.rty = 1'b0;
        resp_d.err = OKAY;
        resp_d.pri = 4'd7;
        resp_d.tid = req.tid;
        resp_d.adr = req.adr;
        resp_d.dat = (cs & ~req.we) ? rdata : 64'd0;
    end

    // State registers with synchronous reset; reset overrides a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            blink_q    <= '0;
            duty_q     <= '1;
            bsel_q     <= BSEL_RST;
            prescale_q <= '0;
            hbf_q      <= 1'b0;
            wr_seen_q  <= 1'b0;
            cnt_q      <= '0;
            pre_q      <= '0;
            pwm_q      <= '0;
            led_q      <= '0;
            resp_q     <= '0;
        end else begin
            out_q      <= out_d;
            blink_q    <= blink_d;
            duty_q     <= duty_d;
            bsel_q     <= bsel_d;
            prescale_q <= prescale_d;
            hbf_q      <= hbf_d;
            wr_seen_q  <= wr_seen_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            pwm_q      <= pwm_d;
            led_q      <= led_d;
            resp_q     <= resp_d;
        end
    end

    assign led  = led_q;
    assign resp = resp_q;

endmodule
